piso_tx_sequencer: RTL and testbench



---
 rtl/piso_tx_sequencer_if.sv | 32 +++
 rtl/piso_tx_sequencer.sv | 119 +++++++++++
 tb/tb_piso_tx_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_sequencer_if.sv
// Handshake and register-control bundle between a word producer, the
// piso_tx_sequencer and the triple-redundant shift register below it.
// The slave modport is the sequencer's view; master is the surrounding side.
interface piso_tx_sequencer_if #(
  parameter int unsigned Width = 4
) ();
  logic [Width-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             abort;
  logic             reg_enable;
  logic [1:0]       reg_mode;
  logic             reg_load;
  logic [Width-1:0] reg_parallel_in;
  logic             reg_serial_in;
  logic             reg_serial_out;
  logic             tx_bit;
  logic             tx_valid;
  logic             frame_done;

  modport slave (
    input  data_in, data_valid, abort, reg_serial_out,
    output data_ready, reg_enable, reg_mode, reg_load, reg_parallel_in,
           reg_serial_in, tx_bit, tx_valid, frame_done
  );

  modport master (
    output data_in, data_valid, abort, reg_serial_out,
    input  data_ready, reg_enable, reg_mode, reg_load, reg_parallel_in,
           reg_serial_in, tx_bit, tx_valid, frame_done
  );
endinterface

// File: rtl/piso_tx_sequencer.sv
// Sequencer for one PISO frame through the triple-redundant shift register:
// accept a word, load it, shift it out LSB first, pulse frame_done.
// Optional feature macro: PISO_TX_SEQ_PARITY_EN appends an even-parity bit.
module piso_tx_sequencer #(
  parameter int unsigned Width = 4
) (
  input logic                 clk,
  input logic                 rst,
  piso_tx_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(Width + 1);

`ifdef PISO_TX_SEQ_PARITY_EN
  typedef enum logic [2:0] {StIdle, StLoad, StShift, StParity, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone} state_e;
`endif

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic [Width-1:0]  r_word, w_word_next;
`ifdef PISO_TX_SEQ_PARITY_EN
  logic              r_parity, w_parity_next;
`endif

  // Register is always in PISO mode and fed zeros from the serial side.
  assign bus.reg_mode        = 2'b10;
  assign bus.reg_serial_in   = 1'b0;
  assign bus.reg_parallel_in = r_word;

  // State, bit counter, captured word and parity flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_word   <= '0;
`ifdef PISO_TX_SEQ_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_word   <= w_word_next;
`ifdef PISO_TX_SEQ_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_word_next    = r_word;
`ifdef PISO_TX_SEQ_PARITY_EN
    w_parity_next  = r_parity;
`endif
    bus.data_ready = 1'b0;
    bus.reg_enable = 1'b0;
    bus.reg_load   = 1'b0;
    bus.tx_bit     = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.frame_done = 1'b0;

    case (r_state)
      StIdle: begin
        bus.data_ready = 1'b1;
        // abort is ignored here, so a same-cycle accept always wins
        if (bus.data_valid) begin
          w_word_next   = bus.data_in;
`ifdef PISO_TX_SEQ_PARITY_EN
          w_parity_next = ^bus.data_in;
`endif
          w_state_next  = StLoad;
        end
      end

      StLoad: begin
        bus.reg_enable = 1'b1;
        bus.reg_load   = 1'b1;
        w_cnt_next     = '0;
        w_state_next   = bus.abort ? StIdle : StShift;
      end

      StShift: begin
        bus.reg_enable = 1'b1;
        bus.tx_valid   = 1'b1;
        bus.tx_bit     = bus.reg_serial_out;
        w_cnt_next     = r_cnt + CntW'(1);
        if (bus.abort) begin
          w_state_next = StIdle;
        end else if (r_cnt == CntW'(Width - 1)) begin
`ifdef PISO_TX_SEQ_PARITY_EN
          w_state_next = StParity;
`else
          w_state_next = StDone;
`endif
        end
      end

`ifdef PISO_TX_SEQ_PARITY_EN
      StParity: begin
        bus.tx_valid = 1'b1;
        bus.tx_bit   = r_parity;
        w_state_next = bus.abort ? StIdle : StDone;
      end
`endif

      StDone: begin
        bus.frame_done = 1'b1;
        w_state_next   = StIdle;
      end

      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Directed bench for piso_tx_sequencer with a behavioural triple-redundant
// PISO register (three copies, majority-voted LSB) hanging off the bus.
module tb_piso_tx_sequencer;

`ifdef PISO_TX_SEQ_PARITY_EN
  localparam int ParEn = 1;
`else
  localparam int ParEn = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  piso_tx_sequencer_if #(.Width(4)) bus ();

  piso_tx_sequencer #(.Width(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register: three copies, shift right, voted LSB out.
  logic [3:0] c0 = 4'b0, c1 = 4'b0, c2 = 4'b0;
  logic [3:0] flip_mask = 4'b0;

  always @(posedge clk) begin
    if (bus.reg_enable && bus.reg_load) begin
      c0 <= bus.reg_parallel_in;
      c1 <= bus.reg_parallel_in;
      c2 <= bus.reg_parallel_in;
    end else if (bus.reg_enable) begin
      c0 <= {bus.reg_serial_in, c0[3:1]};
      c1 <= {bus.reg_serial_in, c1[3:1]} ^ flip_mask;
      c2 <= {bus.reg_serial_in, c2[3:1]};
    end
  end

  assign bus.reg_serial_out = (c0[0] & c1[0]) | (c0[0] & c2[0]) | (c1[0] & c2[0]);

  function automatic logic [7:0] exp_bits(input logic [3:0] w);
    logic [7:0] e;
    e = {4'b0, w};
    if (ParEn == 1) e[4] = ^w;
    return e;
  endfunction

  // Runs one frame from the current mid-cycle position; records what it sees.
  // Returns in the frame_done cycle (or after the cycle budget expires).
  task automatic collect(input logic [3:0] w, input logic [3:0] next_w, input bit hold,
                         input int upset_cyc, output logic [7:0] bits, output int nbits,
                         output int first_v, output int done_cyc, output int load_cyc,
                         output bit rdy0, output bit busy_rdy, output bit mode_bad);
    bits = 8'b0; nbits = 0; first_v = 0; done_cyc = 0; load_cyc = 0;
    busy_rdy = 1'b0; mode_bad = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = w;
    #1;
    rdy0 = bus.data_ready;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      bus.data_in = next_w;
      if (!hold) bus.data_valid = 1'b0;
      flip_mask = (cyc == upset_cyc) ? 4'b0010 : 4'b0000;
      #1;
      if (bus.reg_mode !== 2'b10 || bus.reg_serial_in !== 1'b0) mode_bad = 1'b1;
      if (bus.reg_load === 1'b1 && load_cyc == 0) load_cyc = cyc;
      if (bus.data_ready !== 1'b0) busy_rdy = 1'b1;
      if (bus.tx_valid === 1'b1) begin
        if (first_v == 0) first_v = cyc;
        if (nbits < 8) bits[nbits] = bus.tx_bit;
        nbits++;
      end
      if (bus.frame_done === 1'b1) begin
        done_cyc = cyc;
        flip_mask = 4'b0;
        break;
      end
    end
    flip_mask = 4'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (bus.data_ready !== 1'b1 || bus.reg_enable !== 1'b0 || bus.reg_load !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready/en/load=%b%b%b want 100",
               bus.data_ready, bus.reg_enable, bus.reg_load);
    end
    tests++;
    if (bus.reg_mode !== 2'b10 || bus.reg_serial_in !== 1'b0) begin
      fails++;
      $display("FAIL reset_mode: mode=%b sin=%b want 10 0", bus.reg_mode, bus.reg_serial_in);
    end
    tests++;
    if (bus.reg_parallel_in !== 4'b0) begin
      fails++;
      $display("FAIL reset_pin: got %b want 0000", bus.reg_parallel_in);
    end
    tests++;
    if (bus.tx_bit !== 1'b0 || bus.tx_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx: bit/valid/done=%b%b%b want 000",
               bus.tx_bit, bus.tx_valid, bus.frame_done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (bus.data_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", bus.data_ready);
    end
  endtask

  // Checks one isolated frame of word w, including the ready-return cycle.
  task automatic test_frame(input logic [3:0] w);
    logic [7:0] bits;
    int nbits, first_v, done_cyc, load_cyc;
    bit rdy0, busy_rdy, mode_bad;
    collect(w, ~w, 1'b0, 0, bits, nbits, first_v, done_cyc, load_cyc, rdy0, busy_rdy, mode_bad);
    tests++;
    if (rdy0 !== 1'b1) begin
      fails++; $display("FAIL frame_%b_ready0: got %b want 1", w, rdy0);
    end
    tests++;
    if (load_cyc != 1) begin
      fails++; $display("FAIL frame_%b_load_cyc: got %0d want 1", w, load_cyc);
    end
    tests++;
    if (first_v != 2) begin
      fails++; $display("FAIL frame_%b_first_valid: got %0d want 2", w, first_v);
    end
    tests++;
    if (nbits != 4 + ParEn || bits !== exp_bits(w)) begin
      fails++;
      $display("FAIL frame_%b_bits: got n=%0d %b want n=%0d %b", w, nbits, bits,
               4 + ParEn, exp_bits(w));
    end
    tests++;
    if (done_cyc != 6 + ParEn) begin
      fails++; $display("FAIL frame_%b_done_cyc: got %0d want %0d", w, done_cyc, 6 + ParEn);
    end
    tests++;
    if (busy_rdy !== 1'b0 || mode_bad !== 1'b0) begin
      fails++; $display("FAIL frame_%b_busy: ready_hi=%b mode_bad=%b want 0 0", w, busy_rdy,
                        mode_bad);
    end
    tests++;
    if (bus.tx_bit !== 1'b0 || bus.tx_valid !== 1'b0) begin
      fails++; $display("FAIL frame_%b_done_tx: bit/valid=%b%b want 00", w, bus.tx_bit,
                        bus.tx_valid);
    end
    @(posedge clk);
    #2;
    tests++;
    if (bus.data_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      fails++; $display("FAIL frame_%b_ready_back: ready/done=%b%b want 10", w,
                        bus.data_ready, bus.frame_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bits;
    int nbits, first_v, done_cyc, load_cyc;
    bit rdy0, busy_rdy, mode_bad;
    collect(4'b1111, 4'b0001, 1'b1, 0, bits, nbits, first_v, done_cyc, load_cyc, rdy0,
            busy_rdy, mode_bad);
    tests++;
    if (bits !== exp_bits(4'b1111) || done_cyc != 6 + ParEn || busy_rdy !== 1'b0) begin
      fails++; $display("FAIL b2b_first: bits=%b done=%0d rdy_hi=%b want %b %0d 0", bits,
                        done_cyc, busy_rdy, exp_bits(4'b1111), 6 + ParEn);
    end
    @(posedge clk);
    #2;
    collect(4'b0001, 4'b0110, 1'b0, 0, bits, nbits, first_v, done_cyc, load_cyc, rdy0,
            busy_rdy, mode_bad);
    tests++;
    if (rdy0 !== 1'b1 || load_cyc != 1) begin
      fails++; $display("FAIL b2b_second_accept: ready=%b load_cyc=%0d want 1 1", rdy0,
                        load_cyc);
    end
    tests++;
    if (bits !== exp_bits(4'b0001) || done_cyc != 6 + ParEn || busy_rdy !== 1'b0) begin
      fails++; $display("FAIL b2b_second: bits=%b done=%0d rdy_hi=%b want %b %0d 0", bits,
                        done_cyc, busy_rdy, exp_bits(4'b0001), 6 + ParEn);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_abort;
    bit saw_done;
    bus.data_in = 4'b1010;
    bus.data_valid = 1'b1;
    @(posedge clk); #1 bus.data_valid = 1'b0; #1;   // LOAD
    @(posedge clk); #2;                              // SHIFT bit 0
    tests++;
    if (bus.tx_valid !== 1'b1 || bus.tx_bit !== 1'b0) begin
      fails++; $display("FAIL abort_bit0: valid/bit=%b%b want 10", bus.tx_valid, bus.tx_bit);
    end
    @(posedge clk); #1 bus.abort = 1'b1; #1;        // SHIFT bit 1, abort sampled
    tests++;
    if (bus.tx_valid !== 1'b1 || bus.tx_bit !== 1'b1) begin
      fails++; $display("FAIL abort_bit1: valid/bit=%b%b want 11", bus.tx_valid, bus.tx_bit);
    end
    @(posedge clk); #1 bus.abort = 1'b0; #1;
    tests++;
    if (bus.tx_valid !== 1'b0 || bus.data_ready !== 1'b1) begin
      fails++; $display("FAIL abort_idle: valid/ready=%b%b want 01", bus.tx_valid,
                        bus.data_ready);
    end
    saw_done = bus.frame_done;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (bus.frame_done === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++; $display("FAIL abort_no_done: got %b want 0", saw_done);
    end
    test_frame(4'b0011);
  endtask

  task automatic test_rst_mid_frame;
    bus.data_in = 4'b0101;
    bus.data_valid = 1'b1;
    @(posedge clk); #1 bus.data_valid = 1'b0; #1;
    @(posedge clk); #2;
    @(posedge clk); #2 rst = 1'b1; #1;
    tests++;
    if (bus.data_ready !== 1'b1 || bus.reg_enable !== 1'b0 || bus.reg_load !== 1'b0 ||
        bus.tx_valid !== 1'b0 || bus.tx_bit !== 1'b0 || bus.frame_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: rdy/en/ld/v/b/d=%b%b%b%b%b%b want 100000",
                        bus.data_ready, bus.reg_enable, bus.reg_load, bus.tx_valid,
                        bus.tx_bit, bus.frame_done);
    end
    tests++;
    if (bus.reg_parallel_in !== 4'b0 || bus.reg_mode !== 2'b10) begin
      fails++; $display("FAIL rst_mid_reg: pin=%b mode=%b want 0000 10", bus.reg_parallel_in,
                        bus.reg_mode);
    end
    @(posedge clk); #1 rst = 1'b0; #1;
    tests++;
    if (bus.data_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_release: ready/done=%b%b want 10", bus.data_ready,
                        bus.frame_done);
    end
    test_frame(4'b1000);
  endtask

  task automatic test_upset;
    logic [7:0] bits;
    int nbits, first_v, done_cyc, load_cyc;
    bit rdy0, busy_rdy, mode_bad;
    collect(4'b1101, 4'b0000, 1'b0, 3, bits, nbits, first_v, done_cyc, load_cyc, rdy0,
            busy_rdy, mode_bad);
    tests++;
    if (bits !== exp_bits(4'b1101) || nbits != 4 + ParEn) begin
      fails++; $display("FAIL upset_bits: got n=%0d %b want n=%0d %b", nbits, bits,
                        4 + ParEn, exp_bits(4'b1101));
    end
    tests++;
    if (done_cyc != 6 + ParEn) begin
      fails++; $display("FAIL upset_done_cyc: got %0d want %0d", done_cyc, 6 + ParEn);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    bus.data_in    = 4'b0;
    bus.data_valid = 1'b0;
    bus.abort      = 1'b0;
    test_reset();
    test_frame(4'b1011);
    test_frame(4'b0110);
    test_back_to_back();
    test_abort();
    test_rst_mid_frame();
    test_upset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
